// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the result/bus slot format and CDB sizing defaults.
package rv32i_types;

    // Number of common-data-bus write ports toward the reorder buffer.
    localparam int CDB_PORTS = 2;
    // Number of result requesters: 0-7 ACU RS, 8-15 BR RS, 16 LSQ.
    localparam int CDB_REQS  = 17;

    // Result slot: rdy marks a pending request (on req) or a valid slot (on cdb).
    typedef struct packed {
        logic [3:0]  tag;
        logic        rdy;
        logic [31:0] data;
    } sal_t;

endpackage

// File: rtl/cdb_rr_picker.sv
// Circular first-set picker: returns the first set bit of mask_i at or after
// start_i, wrapping past N-1 back to 0, as a one-hot vector.
module cdb_rr_picker #(
    parameter int N = 17,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] start_i,
    output logic [N-1:0] pick_o,
    output logic         valid_o
);

    logic [W-1:0] idx;

    // Walk the requesters in circular order and keep only the first hit.
    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int off = 0; off < N; off++) begin
            idx = W'((int'(start_i) + off) % N);
            if (!valid_o && mask_i[idx]) begin
                pick_o[idx] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to N_PORTS result requesters per cycle onto
// the common data bus. Grants (ack) are combinational; bus slots are registered.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int N_REQ   = CDB_REQS,
    parameter int N_PORTS = CDB_PORTS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  sal_t [N_REQ-1:0]        req,
    output logic [N_REQ-1:0]        ack,
    output sal_t [N_PORTS-1:0]      cdb
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]                  rr_ptr_q;
    logic [PW-1:0]                  rr_ptr_d;
    sal_t [N_PORTS-1:0]             cdb_q;
    sal_t [N_PORTS-1:0]             cdb_d;

    logic [N_REQ-1:0]               rdy_vec;
    logic [N_PORTS-1:0][N_REQ-1:0]  avail;
    logic [N_PORTS-1:0][N_REQ-1:0]  pick;
    logic [N_PORTS-1:0]             pick_vld;
    logic [N_REQ-1:0]               grant_all;

    // Collect the pending bits of all requesters into one mask.
    always_comb begin
        rdy_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rdy_vec[i] = req[i].rdy;
        end
    end

    // Every picker starts at rr_ptr; each later one sees the earlier picks
    // removed, so port k receives the k-th pending requester in scan order.
    for (genvar p = 0; p < N_PORTS; p++) begin : g_pick
        if (p == 0) begin : g_first
            assign avail[p] = rdy_vec;
        end else begin : g_next
            assign avail[p] = avail[p-1] & ~pick[p-1];
        end

        cdb_rr_picker #(
            .N (N_REQ),
            .W (PW)
        ) u_picker (
            .mask_i  (avail[p]),
            .start_i (rr_ptr_q),
            .pick_o  (pick[p]),
            .valid_o (pick_vld[p])
        );
    end

    // Merge the per-port one-hot picks into the per-requester grant vector.
    always_comb begin
        grant_all = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            grant_all = grant_all | pick[p];
        end
    end

    // Reset and flush both suppress grants in the cycle they are asserted.
    assign ack = (rst || flush) ? '0 : grant_all;

    // Route each port's granted requester to its slot and advance the pointer
    // past the last grant; later ports overwrite, so the last grant wins.
    always_comb begin
        cdb_d    = '0;
        rr_ptr_d = rr_ptr_q;
        if (!flush) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (pick_vld[p]) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick[p][i]) begin
                            cdb_d[p] = req[i];
                            rr_ptr_d = (i == N_REQ - 1) ? '0 : PW'(i + 1);
                        end
                    end
                end
            end
        end
    end

    // Register bus slots and pointer; reset dominates flush and requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            cdb_q    <= cdb_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based scan model.
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int N = CDB_REQS;
    localparam int P = CDB_PORTS;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    sal_t [N-1:0]   req;
    logic [N-1:0]   ack;
    sal_t [P-1:0]   cdb;

    cdb_arbiter #(
        .N_REQ   (N),
        .N_PORTS (P)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .req   (req),
        .ack   (ack),
        .cdb   (cdb)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           m_ptr  = 0;
    sal_t [P-1:0] m_cdb;
    int           g[$];
    logic [N-1:0] last_ack;

    typedef struct {
        logic         r;
        logic         f;
        logic [N-1:0] rdy;
        logic [N-1:0] exp_ack;
        int           exp_ptr;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic r, input logic f, input logic [N-1:0] rdy,
                                input logic [N-1:0] a, input int ptr);
        vec_t v;
        v.r = r; v.f = f; v.rdy = rdy; v.exp_ack = a; v.exp_ptr = ptr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: list pending requesters in circular order from the pointer,
    // keep the first P of them.
    function automatic void model_scan();
        int i;
        g.delete();
        if (rst || flush) return;
        for (int off = 0; off < N; off++) begin
            i = (m_ptr + off) % N;
            if (req[i].rdy && g.size() < P) g.push_back(i);
        end
    endfunction

    task automatic set_reqs(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            req[i].tag  = 4'(i % 16);
            req[i].rdy  = mask[i];
            req[i].data = 32'hA000_0000 | 32'(i);
        end
    endtask

    // One clock: inputs already driven after a negedge. Checks ack, then the
    // registered slots and pointer after the posedge; returns at next negedge.
    task automatic cycle(input string name, input logic use_t,
                         input logic [N-1:0] t_ack, input int t_ptr);
        logic [N-1:0] exp_ack;
        model_scan();
        // Upstream guarantees distinct tags among simultaneous grants.
        for (int k = 1; k < g.size(); k++)
            for (int j = 0; j < k; j++)
                if (req[g[k]].tag == req[g[j]].tag) req[g[k]].tag = req[g[j]].tag + 4'd1;
        exp_ack = '0;
        foreach (g[k]) exp_ack[g[k]] = 1'b1;
        #1;
        last_ack = ack;
        chk({name, " ack"}, 64'(ack), 64'(exp_ack));
        if (use_t) chk({name, " ack(table)"}, 64'(ack), 64'(t_ack));
        m_cdb = '0;
        if (rst) begin
            m_ptr = 0;
        end else if (!flush) begin
            foreach (g[k]) m_cdb[k] = req[g[k]];
            if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % N;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < P; k++)
            chk($sformatf("%s cdb%0d", name, k), 64'(cdb[k]), 64'(m_cdb[k]));
        chk({name, " rr_ptr"}, 64'(dut.rr_ptr_q), 64'(m_ptr));
        if (use_t) chk({name, " rr_ptr(table)"}, 64'(dut.rr_ptr_q), 64'(t_ptr));
        if (cdb[0].rdy && cdb[1].rdy) begin
            checks++;
            assert (cdb[0].tag != cdb[1].tag)
            else begin
                errors++;
                $display("FAIL %s tag_distinct: got %h and %h", name, cdb[0].tag, cdb[1].tag);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; req = '0;
        cycle("reset", 1'b1, '0, 0);
        rst = 1'b0;
    endtask

    sal_t         exp_s;
    logic [N-1:0] pend;
    int           gcount[N];
    logic         seen5;

    initial begin
        rst = 1'b1; flush = 1'b0; req = '0;
        @(negedge clk);
        do_reset();

        tbl[0]  = mk(0, 0, 17'h00008, 17'h00008, 4);
        tbl[1]  = mk(0, 0, 17'h00000, 17'h00000, 4);
        tbl[2]  = mk(0, 0, 17'h10204, 17'h10200, 0);
        tbl[3]  = mk(0, 0, 17'h10204, 17'h00204, 10);
        tbl[4]  = mk(0, 0, 17'h10000, 17'h10000, 0);
        tbl[5]  = mk(0, 1, 17'h00003, 17'h00000, 0);
        tbl[6]  = mk(0, 0, 17'h00003, 17'h00003, 2);
        tbl[7]  = mk(0, 0, 17'h00002, 17'h00002, 2);
        tbl[8]  = mk(1, 0, 17'h00020, 17'h00000, 0);
        tbl[9]  = mk(0, 0, 17'h10001, 17'h10001, 0);
        tbl[10] = mk(0, 0, 17'h1FFFF, 17'h00003, 2);
        for (int v = 0; v < 11; v++) begin
            rst = tbl[v].r; flush = tbl[v].f;
            set_reqs(tbl[v].rdy);
            cycle($sformatf("vec%0d", v), 1'b1, tbl[v].exp_ack, tbl[v].exp_ptr);
        end
        rst = 1'b0; flush = 1'b0;

        // Single request with a known payload.
        do_reset();
        req = '0;
        req[3].tag = 4'd5; req[3].rdy = 1'b1; req[3].data = 32'hDEADBEEF;
        cycle("single", 1'b1, 17'h00008, 4);
        exp_s.tag = 4'd5; exp_s.rdy = 1'b1; exp_s.data = 32'hDEADBEEF;
        chk("single cdb0 payload", 64'(cdb[0]), 64'(exp_s));
        chk("single cdb1 rdy", 64'(cdb[1].rdy), 64'd0);

        // Reset mid-stream: reach rr_ptr=7 with a valid slot, then reset.
        req = '0; set_reqs(17'h00040);
        cycle("pre_rst", 1'b1, 17'h00040, 7);
        chk("pre_rst cdb0 rdy", 64'(cdb[0].rdy), 64'd1);
        rst = 1'b1; flush = 1'b1; set_reqs(17'h1FFFF);
        cycle("mid_rst", 1'b1, '0, 0);
        chk("mid_rst cdb", 64'(cdb), 64'd0);
        rst = 1'b0; flush = 1'b0;

        // Early drop: 5 pending behind 3 and 4, then withdraws.
        set_reqs(17'h00038);
        req[5].data = 32'h5555_0005;
        cycle("drop0", 1'b1, 17'h00018, 5);
        seen5 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_reqs(17'h00000);
            cycle($sformatf("drop%0d", c + 1), 1'b0, '0, 0);
            for (int k = 0; k < P; k++)
                if (cdb[k].rdy && cdb[k].data == 32'h5555_0005) seen5 = 1'b1;
            if (last_ack[5]) seen5 = 1'b1;
        end
        chk("drop never granted", 64'(seen5), 64'd0);
        chk("drop ptr held", 64'(dut.rr_ptr_q), 64'd5);

        // Fairness: everyone pending, each drops once acknowledged.
        pend = '1;
        for (int i = 0; i < N; i++) gcount[i] = 0;
        for (int c = 0; c < 9; c++) begin
            set_reqs(pend);
            cycle($sformatf("fair%0d", c), 1'b0, '0, 0);
            for (int i = 0; i < N; i++) if (last_ack[i]) gcount[i]++;
            pend = pend & ~last_ack;
        end
        chk("fair all served", 64'(pend), 64'd0);
        for (int i = 0; i < N; i++)
            chk($sformatf("fair count%0d", i), 64'(gcount[i]), 64'd1);

        // Randomized traffic against the scan model.
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom % 50) == 0;
            flush = ($urandom % 12) == 0;
            for (int i = 0; i < N; i++) begin
                req[i].tag  = 4'($urandom);
                req[i].rdy  = ($urandom % 3) == 0;
                req[i].data = $urandom;
            end
            cycle("rand", 1'b0, '0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 17, number of result requesters (indices 0-7 ACU RS, 8-15 BR RS, 16 LSQ).
REQ-002 Parameter N_PORTS, default 2, number of common-data-bus write ports toward the reorder buffer.
REQ-003 Port clk  input  1  clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset: synchronous, active-high.
REQ-005 Port flush  input  1  squash of in-flight results (branch mispredict recovery).
REQ-006 Port req  input  sal_t[N_REQ]  per-requester result; .rdy=1 means request pending, plus .tag (4b) and .data (32b).
REQ-007 Port ack  output  1[N_REQ]  combinational same-cycle grant per requester.
REQ-008 Port cdb  output  sal_t[N_PORTS]  registered granted results; .rdy=1 marks a valid slot.

Function
REQ-009 Each cycle the block SHALL scan requesters circularly, starting at rr_ptr and covering rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ..., rr_ptr-1.
REQ-010 The first N_PORTS requesters found with req[i].rdy=1 SHALL receive ack[i]=1 in the same cycle.
REQ-011 The k-th granted requester in scan order SHALL be written into cdb[k] at the next posedge (1-cycle latency).
REQ-012 Ports with no grant SHALL register cdb[k] = all-zero (rdy=0).
REQ-013 When at least one grant occurs, rr_ptr SHALL be set to (index of last granted requester + 1) mod N_REQ.
REQ-014 When no grant occurs, rr_ptr SHALL hold its value.
REQ-015 Wrap: a scan starting at N_REQ-1 SHALL continue at index 0; rr_ptr = N_REQ-1 with grant at N_REQ-1 SHALL give next rr_ptr = 0.
REQ-016 Fewer pending requests than N_PORTS: all pending requests SHALL be granted, filling the low port indices in scan order.
REQ-017 Requester contract: req[i] is held stable until ack[i]=1; a requester deasserting rdy before ack forfeits its request, and the arbiter SHALL carry no memory of it.
REQ-018 A requester SHALL be granted at most one port per cycle.
REQ-019 Starvation bound: any continuously pending requester SHALL be granted within ceil(N_REQ/N_PORTS) cycles.
REQ-020 flush=1 SHALL force ack to all zero that cycle.
REQ-021 flush=1 SHALL register cdb to all zero at the next posedge and SHALL hold rr_ptr.
REQ-022 flush has priority over any pending grant.
REQ-023 The arbiter SHALL NOT check tags; tags of simultaneous grants are distinct by upstream guarantee, and the bench SHALL assert this.
REQ-024 cdb data and tag SHALL be copied bit-exact from the granted req; no arithmetic on payload.
REQ-025 rr_ptr width SHALL be $clog2(N_REQ).

Reset
REQ-026 While rst=1, ack SHALL be all zero combinationally.
REQ-027 At a posedge with rst=1, every cdb[k] SHALL become all zero and rr_ptr SHALL become 0.
REQ-028 rst SHALL take priority over flush and over any pending request.
REQ-029 rst asserted mid-stream SHALL discard registered results and lose no other state, since the arbiter holds none beyond rr_ptr and cdb.

Structure
REQ-030 sal_t SHALL remain in rv32i_types.
REQ-031 Constants CDB_PORTS=2 and CDB_REQS=17 SHALL be added to rv32i_types and used as parameter defaults.
REQ-032 A single combinational sub-module cdb_rr_picker SHALL be used, with inputs request mask and start pointer and outputs one-hot pick and valid.
REQ-033 cdb_rr_picker SHALL be instantiated N_PORTS times, each instance masking the previous instances' picks.
REQ-034 The target size of the top plus the sub-module is 120-250 lines.

Verification
REQ-035 Single request: after reset, req[3]={tag 5, rdy 1, data 0xDEADBEEF} -> ack[3]=1 same cycle; next cycle cdb[0]={5,1,0xDEADBEEF}, cdb[1].rdy=0, rr_ptr=4.
REQ-036 Contention: rr_ptr=0, req 2, 9 and 16 all pending -> acks to 2 and 9; cdb[0]=req2, cdb[1]=req9, rr_ptr=10; next cycle req16 is granted on cdb[0] with rr_ptr=0 (wrap).
REQ-037 Fairness: all 17 requesters held pending for 9 cycles -> each granted exactly once within cycles 1-9, with no double grants.
REQ-038 Flush: req[0] and req[1] pending with flush=1 -> ack=0; next cycle cdb all zero and rr_ptr unchanged.
REQ-039 Reset mid-stream: cdb[0].rdy=1 and rr_ptr=7, then rst=1 for one cycle -> cdb all zero, rr_ptr=0, ack=0 during rst.
REQ-040 Early drop: req[5] rdy for one cycle without grant (two higher-priority requests granted), then drops -> req[5] is never granted and never appears on cdb.
